// File: rtl/cache_ctrl_dm.sv
// Direct-mapped, write-through, no-write-allocate cache controller with one-word lines
// held in flops and saturating read hit/miss counters.
module cache_ctrl_dm #(
    parameter int unsigned AWIDTH   = 3,
    parameter int unsigned DWIDTH   = 32,
    parameter int unsigned IDX_BITS = 1,
    parameter int unsigned CWIDTH   = 8
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [AWIDTH-1:0] cpu_addr,
    input  logic [DWIDTH-1:0] cpu_wdata,
    output logic              cpu_ready,
    output logic              cpu_done,
    output logic [DWIDTH-1:0] cpu_rdata,
    output logic [AWIDTH-1:0] mem_addr,
    output logic [DWIDTH-1:0] mem_din,
    output logic              mem_we,
    input  logic [DWIDTH-1:0] mem_dout,
    output logic [CWIDTH-1:0] hit_cnt,
    output logic [CWIDTH-1:0] miss_cnt
);
    localparam int unsigned LINES = 1 << IDX_BITS;
    localparam int unsigned TW    = AWIDTH - IDX_BITS;

    typedef enum logic [2:0] {IDLE, LOOKUP, RD_ADDR, RD_DATA, WR} state_t;

    state_t              state_q, state_d;
    logic [AWIDTH-1:0]   req_addr;
    logic                req_we;
    logic [DWIDTH-1:0]   req_wdata;
    logic [TW-1:0]       tag_q  [LINES];
    logic [DWIDTH-1:0]   data_q [LINES];
    logic [LINES-1:0]    valid_q;
    logic [IDX_BITS-1:0] req_idx;
    logic [TW-1:0]       req_tag;
    logic                hit;
    logic                accept;
    logic                done_d;
    logic                hit_inc;
    logic                miss_inc;
    logic                fill;
    logic                wr_upd;
    logic [DWIDTH-1:0]   rdata_d;

    assign req_idx  = req_addr[IDX_BITS-1:0];
    assign req_tag  = req_addr[AWIDTH-1:IDX_BITS];
    assign hit      = valid_q[req_idx] && (tag_q[req_idx] == req_tag);
    assign accept   = cpu_req && cpu_ready;
    // The memory port is driven straight from the latched request registers
    assign mem_addr = req_addr;
    assign mem_din  = req_wdata;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d  = state_q;
        done_d   = 1'b0;
        rdata_d  = cpu_rdata;
        hit_inc  = 1'b0;
        miss_inc = 1'b0;
        fill     = 1'b0;
        wr_upd   = 1'b0;
        case (state_q)
            IDLE: begin
                if (accept) state_d = LOOKUP;
            end
            LOOKUP: begin
                if (req_we) begin
                    state_d = WR;
                end else if (hit) begin
                    rdata_d = data_q[req_idx];
                    done_d  = 1'b1;
                    hit_inc = 1'b1;
                    state_d = IDLE;
                end else begin
                    miss_inc = 1'b1;
                    state_d  = RD_ADDR;
                end
            end
            RD_ADDR: state_d = RD_DATA;
            RD_DATA: begin
                fill    = 1'b1;
                rdata_d = mem_dout;
                done_d  = 1'b1;
                state_d = IDLE;
            end
            WR: begin
                wr_upd  = hit;
                done_d  = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Request latch, valid bits, registered CPU/memory outputs and counters
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            req_addr  <= '0;
            req_we    <= 1'b0;
            req_wdata <= '0;
            valid_q   <= '0;
            cpu_ready <= 1'b1;
            cpu_done  <= 1'b0;
            cpu_rdata <= '0;
            mem_we    <= 1'b0;
            hit_cnt   <= '0;
            miss_cnt  <= '0;
        end else begin
            if (accept) begin
                req_addr  <= cpu_addr;
                req_we    <= cpu_we;
                req_wdata <= cpu_wdata;
            end
            if (fill) valid_q[req_idx] <= 1'b1;
            cpu_ready <= (state_d == IDLE);
            cpu_done  <= done_d;
            cpu_rdata <= rdata_d;
            mem_we    <= (state_d == WR);
            if (hit_inc && (hit_cnt != '1))   hit_cnt  <= hit_cnt + CWIDTH'(1);
            if (miss_inc && (miss_cnt != '1)) miss_cnt <= miss_cnt + CWIDTH'(1);
        end
    end

    // Tag and data arrays carry no reset; valid_q alone qualifies them
    always_ff @(posedge clock) begin
        if (fill) begin
            tag_q[req_idx]  <= req_tag;
            data_q[req_idx] <= mem_dout;
        end else if (wr_upd) begin
            data_q[req_idx] <= req_wdata;
        end
    end

endmodule

// File: tb/tb_cache_ctrl_dm.sv
// Scoreboard bench for cache_ctrl_dm: a driver pushes expected completions from a
// behavioural cache/memory model, a monitor pops and compares on every cpu_done.
module tb_cache_ctrl_dm;
    localparam int AW   = 3;
    localparam int DW   = 32;
    localparam int IB   = 1;
    localparam int CW   = 2;
    localparam int CMAX = 3;
    localparam int NW   = 1 << AW;
    localparam int NL   = 1 << IB;

    logic          clock = 1'b0;
    logic          reset;
    logic          cpu_req;
    logic          cpu_we;
    logic [AW-1:0] cpu_addr;
    logic [DW-1:0] cpu_wdata;
    logic          cpu_ready;
    logic          cpu_done;
    logic [DW-1:0] cpu_rdata;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_din;
    logic          mem_we;
    logic [DW-1:0] mem_dout;
    logic [CW-1:0] hit_cnt;
    logic [CW-1:0] miss_cnt;

    always #5 clock = ~clock;

    cache_ctrl_dm #(.AWIDTH(AW), .DWIDTH(DW), .IDX_BITS(IB), .CWIDTH(CW)) dut (
        .clock(clock), .reset(reset),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_ready(cpu_ready), .cpu_done(cpu_done), .cpu_rdata(cpu_rdata),
        .mem_addr(mem_addr), .mem_din(mem_din), .mem_we(mem_we), .mem_dout(mem_dout),
        .hit_cnt(hit_cnt), .miss_cnt(miss_cnt)
    );

    // Single-port synchronous-read RAM
    logic [DW-1:0] ram [NW];
    always @(posedge clock) begin
        mem_dout <= ram[mem_addr];
        if (mem_we) ram[mem_addr] = mem_din;
    end

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    typedef struct {
        bit            rd;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
        int            lat;
        int            hits;
        int            misses;
        int            acc_cyc;
    } exp_t;

    exp_t          sbq[$];
    logic [DW-1:0] ref_mem [NW];
    bit            line_v [NL];
    logic [AW-1:0] line_a [NL];
    int            m_hits;
    int            m_misses;
    int            we_cnt = 0;
    int            n_checks = 0;
    int            n_pass = 0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at cycle %0d", nm, act, exp, cyc);
    endtask

    // Reference: memory is the truth, a line remembers which address it holds
    task automatic model_push(input bit we, input logic [AW-1:0] a, input logic [DW-1:0] d);
        exp_t e;
        int   idx;
        idx       = int'(a) % NL;
        e.rd      = !we;
        e.addr    = a;
        e.acc_cyc = cyc;
        if (we) begin
            ref_mem[a] = d;
            e.data     = d;
            e.lat      = 3;
        end else begin
            if (line_v[idx] && line_a[idx] == a) begin
                e.lat = 2;
                if (m_hits < CMAX) m_hits++;
            end else begin
                e.lat = 4;
                if (m_misses < CMAX) m_misses++;
                line_v[idx] = 1'b1;
                line_a[idx] = a;
            end
            e.data = ref_mem[a];
        end
        e.hits   = m_hits;
        e.misses = m_misses;
        sbq.push_back(e);
    endtask

    always @(negedge clock) begin
        if (!reset) begin
            if (mem_we) begin
                we_cnt++;
                if (sbq.size() == 0 || sbq[0].rd) begin
                    check("mem_we_outside_write", 32'(mem_we), 32'd0);
                end else begin
                    check("wr_mem_addr", 32'(mem_addr), 32'(sbq[0].addr));
                    check("wr_mem_din", mem_din, sbq[0].data);
                end
            end
            if (cpu_done) begin
                if (sbq.size() == 0) begin
                    check("spurious_done", 32'(cpu_done), 32'd0);
                end else begin
                    exp_t e;
                    e = sbq.pop_front();
                    check("latency", 32'(cyc - e.acc_cyc), 32'(e.lat));
                    if (e.rd) check("rdata", cpu_rdata, e.data);
                    check("hit_cnt", 32'(hit_cnt), 32'(e.hits));
                    check("miss_cnt", 32'(miss_cnt), 32'(e.misses));
                    check("mem_we_pulses", 32'(we_cnt), e.rd ? 32'd0 : 32'd1);
                end
                we_cnt = 0;
            end
        end
    end

    // Called at a negedge; holds cpu_req high until the request is taken
    task automatic issue(input bit we, input logic [AW-1:0] a, input logic [DW-1:0] d);
        int t;
        cpu_req   = 1'b1;
        cpu_we    = we;
        cpu_addr  = a;
        cpu_wdata = d;
        t = 0;
        while (!cpu_ready && t < 30) begin
            @(negedge clock);
            t++;
        end
        if (!cpu_ready) begin
            check("ready_timeout", 32'(cpu_ready), 32'd1);
            cpu_req = 1'b0;
            return;
        end
        model_push(we, a, d);
        @(negedge clock);
        cpu_req = 1'b0;
    endtask

    task automatic drain();
        int t;
        t = 0;
        while (sbq.size() != 0 && t < 40) begin
            @(negedge clock);
            t++;
        end
        check("drain_timeout", 32'(sbq.size()), 32'd0);
    endtask

    task automatic do_reset();
        reset   = 1'b1;
        cpu_req = 1'b0;
        sbq.delete();
        we_cnt   = 0;
        m_hits   = 0;
        m_misses = 0;
        for (int i = 0; i < NL; i++) line_v[i] = 1'b0;
        @(negedge clock);
        check("rst_cpu_ready", 32'(cpu_ready), 32'd1);
        check("rst_cpu_done", 32'(cpu_done), 32'd0);
        check("rst_cpu_rdata", cpu_rdata, 32'd0);
        check("rst_hit_cnt", 32'(hit_cnt), 32'd0);
        check("rst_miss_cnt", 32'(miss_cnt), 32'd0);
        check("rst_mem_we", 32'(mem_we), 32'd0);
        check("rst_mem_addr", 32'(mem_addr), 32'd0);
        check("rst_mem_din", mem_din, 32'd0);
        reset = 1'b0;
        @(negedge clock);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        reset     = 1'b1;
        cpu_req   = 1'b0;
        cpu_we    = 1'b0;
        cpu_addr  = '0;
        cpu_wdata = '0;
        for (int i = 0; i < NW; i++) begin
            ram[i]     = 32'hA0 + 32'(i);
            ref_mem[i] = 32'hA0 + 32'(i);
        end
        @(negedge clock);

        // Miss then hit on the same address
        do_reset();
        issue(1'b0, 3'd5, '0);
        issue(1'b0, 3'd5, '0);
        drain();

        // Write hit updates both line and memory
        do_reset();
        issue(1'b0, 3'd5, '0);
        issue(1'b1, 3'd5, 32'hDEAD);
        issue(1'b0, 3'd5, '0);
        drain();

        // Write miss does not allocate
        do_reset();
        issue(1'b1, 3'd2, 32'h1234);
        issue(1'b0, 3'd2, '0);
        drain();

        // Conflict misses on index 1
        do_reset();
        issue(1'b0, 3'd1, '0);
        issue(1'b0, 3'd3, '0);
        issue(1'b0, 3'd1, '0);
        drain();

        // Reset while the fill of address 6 is in RD_DATA
        do_reset();
        issue(1'b0, 3'd6, '0);
        @(negedge clock);
        @(negedge clock);
        do_reset();
        issue(1'b0, 3'd6, '0);
        drain();

        // Hit counter saturation with back-to-back held requests
        do_reset();
        issue(1'b0, 3'd0, '0);
        for (int i = 0; i < 5; i++) issue(1'b0, 3'd0, '0);
        drain();

        // Randomized traffic with occasional idle gaps
        do_reset();
        for (int i = 0; i < 300; i++) begin
            issue(1'($urandom_range(0, 1)), AW'($urandom_range(0, NW - 1)), $urandom);
            if ($urandom_range(0, 3) == 0) begin
                drain();
                repeat ($urandom_range(0, 2)) @(negedge clock);
            end
        end
        drain();

        for (int i = 0; i < NW; i++) check($sformatf("ram_%0d", i), ram[i], ref_mem[i]);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
